fft_coprocessor_npt: RTL and testbench

FFT_COPROCESSOR_NPT -- requirements
Module: fft_coprocessor_npt

---
 rtl/fft_coprocessor_npt.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_fft_coprocessor_npt.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_coprocessor_npt.sv
// ---------------------------------------------------------------------------
// fft_coprocessor_npt
//
// Command-driven, in-place radix-2 decimation-in-time FFT coprocessor.
// Samples are loaded into bit-reversed locations, so after a START the
// transform result sits in natural order and can be read back directly.
// A single butterfly engine walks every butterfly of every stage. Each
// butterfly takes five cycles: read x, read y and the twiddle, compute,
// write x, and write y.
//
// Compile-time option:
//   FFT_STAGE_SCALE_EN - when defined, each stage result is shifted right by
//                        one (truncating) before saturation. Across all
//                        stages this gives an overall 1/N scaling.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   cmd_valid / cmd_ready        command handshake; ready only while idle
//   cmd[2:0]                     0 NOP, 1 LOAD_SAMPLE, 2 LOAD_TWIDDLE,
//                                3 READ_SAMPLE, 4 START, 5 ABORT, others NOP
//   addr[LOG2N-1:0]              sample index or twiddle index
//   data_in_real / data_in_imag  load data (twiddles in Q1.(DATA_W-2))
//   data_out_real / data_out_imag, data_out_valid
//                                read data; valid pulses one cycle after accept
//   busy                         FFT in progress
//   done                         one-cycle pulse after the final butterfly
//   ovf                          sticky saturation flag, cleared by START
// ---------------------------------------------------------------------------
module fft_coprocessor_npt #(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd,
    input  logic [LOG2N-1:0]         addr,
    input  logic signed [DATA_W-1:0] data_in_real,
    input  logic signed [DATA_W-1:0] data_in_imag,
    output logic signed [DATA_W-1:0] data_out_real,
    output logic signed [DATA_W-1:0] data_out_imag,
    output logic                     data_out_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf
);

    localparam int N      = 1 << LOG2N;
    localparam int HALF   = N / 2;
    localparam int STAGES = LOG2N;
    localparam int SW     = $clog2(STAGES);
    localparam int PRW    = 2 * DATA_W;         // raw product width
    localparam int PW     = 2 * DATA_W + 1;     // sum of two products
    localparam int TW     = DATA_W + 3;         // rounded twiddle product
    localparam int AW     = DATA_W + 4;         // butterfly sum/difference

    localparam logic [2:0] OP_LOAD_SMP = 3'b001;
    localparam logic [2:0] OP_LOAD_TW  = 3'b010;
    localparam logic [2:0] OP_READ     = 3'b011;
    localparam logic [2:0] OP_START    = 3'b100;
    localparam logic [2:0] OP_ABORT    = 3'b101;

    localparam logic [LOG2N-1:0]  ONE_N   = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-2:0]  BF_LAST = '1;
    localparam logic [SW-1:0]     ST_LAST = SW'(STAGES - 1);

    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    // Half an LSB of the Q1.(DATA_W-2) product, for round-half-up.
    localparam logic signed [PW-1:0] RND_C =
        {{(PW-DATA_W+2){1'b0}}, 1'b1, {(DATA_W-3){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_X,
        S_RD_Y,
        S_CALC,
        S_WR_0,
        S_WR_1
    } state_t;

    // ---------------------------------------------------------------------
    // Arithmetic helpers
    // ---------------------------------------------------------------------
    function automatic logic signed [TW-1:0] round_q(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
        r = v + RND_C;
        return TW'(r >>> (DATA_W - 2));
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] v);
        if (v > AW'(MAX_V))
            return MAX_V;
        else if (v < AW'(MIN_V))
            return MIN_V;
        else
            return DATA_W'(v);
    endfunction

    function automatic logic is_sat(input logic signed [AW-1:0] v);
        return (v > AW'(MAX_V)) || (v < AW'(MIN_V));
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++)
            r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Storage and control state
    // ---------------------------------------------------------------------
    logic signed [DATA_W-1:0] smp_re [N];
    logic signed [DATA_W-1:0] smp_im [N];
    logic signed [DATA_W-1:0] tw_re  [HALF];
    logic signed [DATA_W-1:0] tw_im  [HALF];

    state_t state, state_nx;
    logic [SW-1:0]    stage;
    logic [LOG2N-2:0] bfly;
    logic             vld_p0;

    logic accept, abort_cmd, last_bfly;
    logic ld_smp, ld_tw, rd_cmd, start_cmd;

    assign accept    = cmd_valid && cmd_ready;
    // ABORT bypasses the handshake so it can interrupt a running transform.
    assign abort_cmd = cmd_valid && (cmd == OP_ABORT);
    assign ld_smp    = accept && (cmd == OP_LOAD_SMP);
    assign ld_tw     = accept && (cmd == OP_LOAD_TW);
    assign rd_cmd    = accept && (cmd == OP_READ);
    assign start_cmd = accept && (cmd == OP_START);
    assign last_bfly = (bfly == BF_LAST) && (stage == ST_LAST);

    // ---------------------------------------------------------------------
    // Butterfly addressing: x/y pair and twiddle index for (stage, bfly)
    // ---------------------------------------------------------------------
    logic [LOG2N-1:0] bext, span, pos, bx, by;
    logic [LOG2N-2:0] tw_k;

    always_comb begin
        bext = {1'b0, bfly};
        span = ONE_N << stage;
        pos  = bext & (span - ONE_N);
        bx   = (((bext >> stage) << stage) << 1) | pos;
        by   = bx + span;
        tw_k = pos[LOG2N-2:0] << (ST_LAST - stage);
    end

    // The single sample read port is shared by READ_SAMPLE and the engine.
    logic [LOG2N-1:0]         rd_addr;
    logic signed [DATA_W-1:0] rd_re, rd_im;

    always_comb begin
        rd_addr = addr;
        if (state == S_RD_X)
            rd_addr = bx;
        else if (state == S_RD_Y)
            rd_addr = by;
    end

    assign rd_re = smp_re[rd_addr];
    assign rd_im = smp_im[rd_addr];

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_cmd) state_nx = S_RD_X;
            S_RD_X: state_nx = S_RD_Y;
            S_RD_Y: state_nx = S_CALC;
            S_CALC: state_nx = S_WR_0;
            S_WR_0: state_nx = S_WR_1;
            S_WR_1: state_nx = last_bfly ? S_IDLE : S_RD_X;
            default: state_nx = S_IDLE;
        endcase
        if (abort_cmd && (state != S_IDLE))
            state_nx = S_IDLE;
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    assign data_out_valid = vld_p0;

    // ---------------------------------------------------------------------
    // Stage p0: operands captured in RD_X / RD_Y
    // ---------------------------------------------------------------------
    logic signed [DATA_W-1:0] x_re_p0, x_im_p0, y_re_p0, y_im_p0;
    logic signed [DATA_W-1:0] w_re_p0, w_im_p0;

    always_ff @(posedge clk) begin
        if (state == S_RD_X) begin
            x_re_p0 <= rd_re;
            x_im_p0 <= rd_im;
        end
        if (state == S_RD_Y) begin
            y_re_p0 <= rd_re;
            y_im_p0 <= rd_im;
            w_re_p0 <= tw_re[tw_k];
            w_im_p0 <= tw_im[tw_k];
        end
    end

    logic signed [PRW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0]  t_re_full, t_im_full;
    logic signed [TW-1:0]  t_re, t_im;
    logic signed [AW-1:0]  a0_re, a0_im, a1_re, a1_im;
    logic signed [AW-1:0]  s0_re, s0_im, s1_re, s1_im;
    logic                  sat_any;

    always_comb begin
        p_rr      = PRW'(y_re_p0) * PRW'(w_re_p0);
        p_ii      = PRW'(y_im_p0) * PRW'(w_im_p0);
        p_ri      = PRW'(y_re_p0) * PRW'(w_im_p0);
        p_ir      = PRW'(y_im_p0) * PRW'(w_re_p0);
        t_re_full = PW'(p_rr) - PW'(p_ii);
        t_im_full = PW'(p_ri) + PW'(p_ir);
        t_re      = round_q(t_re_full);
        t_im      = round_q(t_im_full);
        a0_re     = AW'(x_re_p0) + AW'(t_re);
        a0_im     = AW'(x_im_p0) + AW'(t_im);
        a1_re     = AW'(x_re_p0) - AW'(t_re);
        a1_im     = AW'(x_im_p0) - AW'(t_im);
`ifdef FFT_STAGE_SCALE_EN
        s0_re     = a0_re >>> 1;
        s0_im     = a0_im >>> 1;
        s1_re     = a1_re >>> 1;
        s1_im     = a1_im >>> 1;
`else
        s0_re     = a0_re;
        s0_im     = a0_im;
        s1_re     = a1_re;
        s1_im     = a1_im;
`endif
        sat_any   = is_sat(s0_re) || is_sat(s0_im) || is_sat(s1_re) || is_sat(s1_im);
    end

    // ---------------------------------------------------------------------
    // Stage p1: saturated butterfly results, written back in WR_0 / WR_1
    // ---------------------------------------------------------------------
    logic signed [DATA_W-1:0] o0_re_p1, o0_im_p1, o1_re_p1, o1_im_p1;

    always_ff @(posedge clk) begin
        if (state == S_CALC) begin
            o0_re_p1 <= sat(s0_re);
            o0_im_p1 <= sat(s0_im);
            o1_re_p1 <= sat(s1_re);
            o1_im_p1 <= sat(s1_im);
        end
    end

    // Sample and twiddle storage. Loads only happen while idle, so they
    // never collide with engine write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                smp_re[i] <= '0;
                smp_im[i] <= '0;
            end
            for (int i = 0; i < HALF; i++) begin
                tw_re[i] <= '0;
                tw_im[i] <= '0;
            end
        end else begin
            if (ld_smp) begin
                smp_re[bitrev(addr)] <= data_in_real;
                smp_im[bitrev(addr)] <= data_in_imag;
            end
            if (ld_tw && !addr[LOG2N-1]) begin
                tw_re[addr[LOG2N-2:0]] <= data_in_real;
                tw_im[addr[LOG2N-2:0]] <= data_in_imag;
            end
            if (state == S_WR_0) begin
                smp_re[bx] <= o0_re_p1;
                smp_im[bx] <= o0_im_p1;
            end
            if (state == S_WR_1) begin
                smp_re[by] <= o1_re_p1;
                smp_im[by] <= o1_im_p1;
            end
        end
    end

    // Control registers: counters, status flags and read-back port.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage         <= '0;
            bfly          <= '0;
            done          <= 1'b0;
            ovf           <= 1'b0;
            vld_p0        <= 1'b0;
            data_out_real <= '0;
            data_out_imag <= '0;
        end else begin
            done   <= (state == S_WR_1) && last_bfly && !abort_cmd;
            vld_p0 <= rd_cmd;
            if (rd_cmd) begin
                data_out_real <= rd_re;
                data_out_imag <= rd_im;
            end
            if (start_cmd)
                ovf <= 1'b0;
            else if ((state == S_CALC) && sat_any)
                ovf <= 1'b1;
            if (state == S_IDLE) begin
                stage <= '0;
                bfly  <= '0;
            end else if (state == S_WR_1) begin
                if (bfly == BF_LAST) begin
                    bfly  <= '0;
                    stage <= stage + 1'b1;
                end else begin
                    bfly <= bfly + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_coprocessor_npt.sv
// ---------------------------------------------------------------------------
// tb_fft_coprocessor_npt
//
// Self-checking bench for fft_coprocessor_npt with N=8, DATA_W=16. Read-back
// expectations are queued when a READ_SAMPLE is issued and popped when the
// data appears. FFT_STAGE_SCALE_EN selects the scaled expectations.
// ---------------------------------------------------------------------------
module tb_fft_coprocessor_npt;

    localparam int LOG2N  = 3;
    localparam int DATA_W = 16;
    localparam int N      = 8;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_LDS   = 3'd1;
    localparam logic [2:0] C_LDT   = 3'd2;
    localparam logic [2:0] C_RD    = 3'd3;
    localparam logic [2:0] C_START = 3'd4;
    localparam logic [2:0] C_ABORT = 3'd5;

`ifdef FFT_STAGE_SCALE_EN
    localparam int IMP_OUT = 125;
    localparam int DC_OUT  = 1000;
`else
    localparam int IMP_OUT = 1000;
    localparam int DC_OUT  = 8000;
`endif

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [2:0]               cmd;
    logic [LOG2N-1:0]         addr;
    logic signed [DATA_W-1:0] din_re, din_im, dout_re, dout_im;
    logic                     dov, busy, done, ovf;

    cplx_t sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    in_re [N];
    int    in_im [N];
    int    ex_re [N];
    int    ex_im [N];
    int    brev  [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    fft_coprocessor_npt #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .addr          (addr),
        .data_in_real  (din_re),
        .data_in_imag  (din_im),
        .data_out_real (dout_re),
        .data_out_imag (dout_im),
        .data_out_valid(dov),
        .busy          (busy),
        .done          (done),
        .ovf           (ovf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted; returns one cycle after
    // the accepting edge.
    task automatic do_cmd(input logic [2:0] op, input int a, input int re, input int im);
        logic acc;
        int   guard;
        cmd       = op;
        addr      = a[LOG2N-1:0];
        din_re    = re[15:0];
        din_im    = im[15:0];
        cmd_valid = 1'b1;
        acc       = 1'b0;
        guard     = 0;
        while (!acc && guard < 500) begin
            acc = cmd_ready;
            cyc();
            guard++;
        end
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL cmd_accept op=%0d: accepted=%0d after %0d cycles, required 1", op, acc, guard);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++)
            do_cmd(C_LDS, i, in_re[i], in_im[i]);
    endtask

    task automatic load_twiddles();
        do_cmd(C_LDT, 0, 16384, 0);
        do_cmd(C_LDT, 1, 11585, -11585);
        do_cmd(C_LDT, 2, 0, -16384);
        do_cmd(C_LDT, 3, -11585, -11585);
        // Index beyond N/2 must be ignored (would alias entry 0 if not).
        do_cmd(C_LDT, 4, 123, 456);
    endtask

    task automatic run_fft(output int lat, output logic busy1, output logic ovf1,
                           output logic busy_d, output logic rdy_d);
        do_cmd(C_START, 0, 0, 0);
        lat   = 1;
        busy1 = busy;
        ovf1  = ovf;
        while (done !== 1'b1 && lat < 400) begin
            cyc();
            lat++;
        end
        busy_d = busy;
        rdy_d  = cmd_ready;
    endtask

    task automatic test_reset();
        cplx_t e;
        n_cmp++;
        if ({cmd_ready, busy, done, ovf, dov} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/busy/done/ovf/dov=%b required 10000",
                     {cmd_ready, busy, done, ovf, dov});
        end
        n_cmp++;
        if (dout_re !== 16'sd0 || dout_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_dout: got (%0d,%0d) required (0,0)", dout_re, dout_im);
        end
        e.re = 16'sd0;
        e.im = 16'sd0;
        sb.push_back(e);
        do_cmd(C_RD, 3, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
            n_fail++;
            $display("FAIL reset_read: vld=%b got (%0d,%0d) required (%0d,%0d)",
                     dov, dout_re, dout_im, e.re, e.im);
        end
    endtask

    task automatic test_load_read();
        cplx_t e;
        for (int i = 0; i < N; i++) begin
            in_re[i] = 100 + 3 * i;
            in_im[i] = -(i + 1);
        end
        load_all();
        for (int k = 0; k < N; k++) begin
            e.re = 16'(in_re[brev[k]]);
            e.im = 16'(in_im[brev[k]]);
            sb.push_back(e);
            do_cmd(C_RD, k, 0, 0);
            e = sb.pop_front();
            n_cmp++;
            if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
                n_fail++;
                $display("FAIL load_read addr%0d: vld=%b got (%0d,%0d) required (%0d,%0d)",
                         k, dov, dout_re, dout_im, e.re, e.im);
            end
        end
        cyc();
        n_cmp++;
        if (dov !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse: data_out_valid=%b two cycles after accept, required 0", dov);
        end
    endtask

    task automatic test_impulse();
        cplx_t e;
        int    lat;
        logic  b1, o1, bd, rd;
        for (int i = 0; i < N; i++) begin
            in_re[i] = (i == 0) ? 1000 : 0;
            in_im[i] = 0;
            ex_re[i] = IMP_OUT;
            ex_im[i] = 0;
        end
        load_all();
        run_fft(lat, b1, o1, bd, rd);
        n_cmp++;
        if (lat !== 61) begin
            n_fail++;
            $display("FAIL impulse_latency: done at %0d cycles after accept, required 61", lat);
        end
        n_cmp++;
        if ({b1, bd, rd} !== 3'b101) begin
            n_fail++;
            $display("FAIL impulse_busy: busy@1/busy@done/ready@done=%b required 101", {b1, bd, rd});
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL impulse_ovf: got %b required 0", ovf);
        end
        for (int k = 0; k < N; k++) begin
            e.re = 16'(ex_re[k]);
            e.im = 16'(ex_im[k]);
            sb.push_back(e);
            do_cmd(C_RD, k, 0, 0);
            e = sb.pop_front();
            n_cmp++;
            if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
                n_fail++;
                $display("FAIL impulse bin%0d: vld=%b got (%0d,%0d) required (%0d,%0d)",
                         k, dov, dout_re, dout_im, e.re, e.im);
            end
        end
    endtask

    task automatic test_dc();
        cplx_t e;
        int    lat;
        logic  b1, o1, bd, rd;
        for (int i = 0; i < N; i++) begin
            in_re[i] = 1000;
            in_im[i] = 0;
            ex_re[i] = (i == 0) ? DC_OUT : 0;
            ex_im[i] = 0;
        end
        load_all();
        run_fft(lat, b1, o1, bd, rd);
        for (int k = 0; k < N; k++) begin
            e.re = 16'(ex_re[k]);
            e.im = 16'(ex_im[k]);
            sb.push_back(e);
            do_cmd(C_RD, k, 0, 0);
            e = sb.pop_front();
            n_cmp++;
            if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
                n_fail++;
                $display("FAIL dc bin%0d: vld=%b got (%0d,%0d) required (%0d,%0d)",
                         k, dov, dout_re, dout_im, e.re, e.im);
            end
        end
    endtask

`ifndef FFT_STAGE_SCALE_EN
    // x[1]=(1000,0): X[k] = 1000*W^k, twiddle products rounded half-up.
    task automatic test_shifted_impulse();
        cplx_t e;
        int    lat;
        logic  b1, o1, bd, rd;
        ex_re = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        ex_im = '{0, -707, -1000, -707, 0, 707, 1000, 707};
        for (int i = 0; i < N; i++) begin
            in_re[i] = (i == 1) ? 1000 : 0;
            in_im[i] = 0;
        end
        load_all();
        run_fft(lat, b1, o1, bd, rd);
        for (int k = 0; k < N; k++) begin
            e.re = 16'(ex_re[k]);
            e.im = 16'(ex_im[k]);
            sb.push_back(e);
            do_cmd(C_RD, k, 0, 0);
            e = sb.pop_front();
            n_cmp++;
            if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
                n_fail++;
                $display("FAIL shifted bin%0d: vld=%b got (%0d,%0d) required (%0d,%0d)",
                         k, dov, dout_re, dout_im, e.re, e.im);
            end
        end
    endtask

    task automatic test_saturation();
        cplx_t e;
        int    lat;
        logic  b1, o1, bd, rd;
        for (int i = 0; i < N; i++) begin
            in_re[i] = 32767;
            in_im[i] = 0;
        end
        load_all();
        run_fft(lat, b1, o1, bd, rd);
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_ovf_set: got %b required 1", ovf);
        end
        e.re = 16'sd32767;
        e.im = 16'sd0;
        sb.push_back(e);
        do_cmd(C_RD, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
            n_fail++;
            $display("FAIL sat bin0: vld=%b got (%0d,%0d) required (%0d,%0d)",
                     dov, dout_re, dout_im, e.re, e.im);
        end
        for (int i = 0; i < N; i++)
            in_re[i] = 0;
        load_all();
        run_fft(lat, b1, o1, bd, rd);
        n_cmp++;
        if (o1 !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_ovf_clear: ovf after START=%b at done=%b required 0/0", o1, ovf);
        end
    endtask
`endif

    task automatic test_abort();
        int n_done;
        for (int i = 0; i < N; i++) begin
            in_re[i] = (i == 0) ? 1000 : 0;
            in_im[i] = 0;
        end
        load_all();
        do_cmd(C_START, 0, 0, 0);
        repeat (19) cyc();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_busy: busy=%b 20 cycles after START, required 1", busy);
        end
        cmd       = C_ABORT;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b ready=%b required 0/1", busy, cmd_ready);
        end
        n_done = 0;
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1)
                n_done++;
            cyc();
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", n_done);
        end
    endtask

    task automatic test_stall();
        cplx_t e;
        logic  acc, acc_done, early_vld;
        int    cnt;
        for (int i = 0; i < N; i++) begin
            in_re[i] = (i == 0) ? 1000 : 0;
            in_im[i] = 0;
        end
        load_all();
        do_cmd(C_START, 0, 0, 0);
        repeat (3) cyc();
        e.re = 16'(IMP_OUT);
        e.im = 16'sd0;
        sb.push_back(e);
        cmd       = C_RD;
        addr      = 3'd5;
        cmd_valid = 1'b1;
        acc       = 1'b0;
        acc_done  = 1'b0;
        early_vld = 1'b0;
        cnt       = 0;
        while (!acc && cnt < 200) begin
            acc      = cmd_ready;
            acc_done = done;
            if (dov === 1'b1)
                early_vld = 1'b1;
            cyc();
            cnt++;
        end
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        n_cmp++;
        if (acc !== 1'b1 || acc_done !== 1'b1 || early_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept: accepted=%b in_done_cycle=%b early_valid=%b required 1/1/0",
                     acc, acc_done, early_vld);
        end
        e = sb.pop_front();
        n_cmp++;
        if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
            n_fail++;
            $display("FAIL stall_read: vld=%b got (%0d,%0d) required (%0d,%0d)",
                     dov, dout_re, dout_im, e.re, e.im);
        end
    endtask

    task automatic test_rst_mid();
        cplx_t e;
        int    n_done;
        for (int i = 0; i < N; i++) begin
            in_re[i] = 500 + i;
            in_im[i] = 7;
        end
        load_all();
        do_cmd(C_START, 0, 0, 0);
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if ({cmd_ready, busy, done, ovf, dov} !== 5'b10000 || dout_re !== 16'sd0 || dout_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: ready/busy/done/ovf/dov=%b dout=(%0d,%0d) required 10000 (0,0)",
                     {cmd_ready, busy, done, ovf, dov}, dout_re, dout_im);
        end
        n_done = 0;
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1)
                n_done++;
            cyc();
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: %0d done pulses, required 0", n_done);
        end
        for (int k = 0; k < 2; k++) begin
            e.re = 16'sd0;
            e.im = 16'sd0;
            sb.push_back(e);
            do_cmd(C_RD, 5 * k + 1, 0, 0);
            e = sb.pop_front();
            n_cmp++;
            if (dov !== 1'b1 || dout_re !== e.re || dout_im !== e.im) begin
                n_fail++;
                $display("FAIL rst_mid_read addr%0d: vld=%b got (%0d,%0d) required (0,0)",
                         5 * k + 1, dov, dout_re, dout_im);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        addr      = '0;
        din_re    = '0;
        din_im    = '0;
        repeat (3) cyc();
        rst = 1'b0;
        test_reset();
        test_load_read();
        load_twiddles();
        test_impulse();
        test_dc();
`ifndef FFT_STAGE_SCALE_EN
        test_shifted_impulse();
        test_saturation();
`endif
        test_abort();
        test_stall();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
